// File: rtl/unary_pkg.sv
// Shared definitions for the unary stream decoder: FSM encoding and
// default geometry (value width, magnitude bits, window length, lanes).
package unary_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int DEF_BIT_WIDTH = 5;
  localparam int DEF_SIZE      = DEF_BIT_WIDTH - 1;
  localparam int DEF_LANES     = 2;
  localparam int DEF_WINDOW    = 2 ** DEF_SIZE;

  // Window length in cycles for a given number of magnitude bits.
  function automatic int window_len(input int size);
    return 2 ** size;
  endfunction

endpackage

// File: rtl/unary_lane_counter.sv
// Saturating ones counter for one unary lane. A clear restarts the count
// from zero while still adding the bit of the same cycle, so the window's
// first sample is never lost. A one arriving at full scale is dropped and
// raises the saturation flag until the next clear.
module unary_lane_counter
  import unary_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            enable,
  input  logic            bit_in,
  output logic [SIZE-1:0] count,
  output logic            sat
);

  localparam logic [SIZE-1:0] MAX_CNT = {SIZE{1'b1}};

  logic [SIZE-1:0] count_r;
  logic            sat_r;
  logic [SIZE-1:0] base_cnt_s;
  logic            base_sat_s;

  // Select the starting point for this cycle: zero on clear, else running total
  always_comb begin
    base_cnt_s = count_r;
    base_sat_s = sat_r;
    if (clear) begin
      base_cnt_s = {SIZE{1'b0}};
      base_sat_s = 1'b0;
    end else begin
      base_cnt_s = count_r;
      base_sat_s = sat_r;
    end
  end

  // Accumulate ones with saturation at full scale
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {SIZE{1'b0}};
      sat_r   <= 1'b0;
    end else if (enable && bit_in) begin
      if (base_cnt_s == MAX_CNT) begin
        count_r <= base_cnt_s;
        sat_r   <= 1'b1;
      end else begin
        count_r <= base_cnt_s + SIZE'(1'b1);
        sat_r   <= base_sat_s;
      end
    end else begin
      count_r <= base_cnt_s;
      sat_r   <= base_sat_s;
    end
  end

  assign count = count_r;
  assign sat   = sat_r;

endmodule

// File: rtl/unary_stream_decoder.sv
// Decodes LANES parallel temporal-unary streams into signed values. Each
// accepted start opens a window of 2^SIZE samples (the accepting cycle is
// sample 0); the per-lane ones count is then signed with the sign latched at
// start and presented on a valid/ready output held until consumed.
module unary_stream_decoder
  import unary_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int SIZE      = BIT_WIDTH - 1,
  parameter int LANES     = DEF_LANES
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [LANES-1:0]           sign_in,
  input  logic [LANES-1:0]           unary_in,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*BIT_WIDTH-1:0] out_data,
  output logic [LANES-1:0]           sat
);

  localparam int              WINDOW   = window_len(SIZE);
  // Index of the last sample already taken when the final one is due.
  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(WINDOW - 2);

  state_t                     state_r;
  state_t                     state_s;
  logic                       accept_s;
  logic                       handshake_s;
  logic                       count_en_s;
  logic [SIZE-1:0]            win_cnt_r;
  logic [LANES-1:0]           sign_r;
  logic [SIZE-1:0]            lane_cnt_s [LANES];
  logic [LANES-1:0]           lane_sat_s;
  logic [LANES*BIT_WIDTH-1:0] decoded_s;
  logic [LANES*BIT_WIDTH-1:0] out_data_r;
  logic [LANES-1:0]           sat_r;
  logic                       out_valid_r;
  logic                       busy_r;

  // Signed value of a lane: zero magnitude yields plain zero for either sign.
  function automatic logic [BIT_WIDTH-1:0] decode_lane(input logic neg,
                                                       input logic [SIZE-1:0] cnt);
    logic [BIT_WIDTH-1:0] mag;
    mag = BIT_WIDTH'(cnt);
    if (neg) begin
      return {BIT_WIDTH{1'b0}} - mag;
    end else begin
      return mag;
    end
  endfunction

  // Next-state logic: start is only honoured in IDLE or on a HOLD handshake
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    handshake_s = out_valid_r & out_ready;
    count_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = ST_COUNT;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (win_cnt_r == LAST_IDX) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_COUNT;
        end
      end
      ST_HOLD: begin
        if (handshake_s) begin
          if (start) begin
            accept_s = 1'b1;
            state_s  = ST_COUNT;
          end else begin
            state_s  = ST_IDLE;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    count_en_s = accept_s | (state_r == ST_COUNT);
  end

  // State register and registered busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // Window counter and sign latch, both restarted on every accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt_r <= {SIZE{1'b0}};
      sign_r    <= {LANES{1'b0}};
    end else if (accept_s) begin
      win_cnt_r <= {SIZE{1'b0}};
      sign_r    <= sign_in;
    end else if (state_r == ST_COUNT) begin
      win_cnt_r <= win_cnt_r + SIZE'(1'b1);
      sign_r    <= sign_r;
    end else begin
      win_cnt_r <= win_cnt_r;
      sign_r    <= sign_r;
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      unary_lane_counter #(
        .SIZE(SIZE)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept_s),
        .enable  (count_en_s),
        .bit_in  (unary_in[g]),
        .count   (lane_cnt_s[g]),
        .sat     (lane_sat_s[g])
      );
      assign decoded_s[g*BIT_WIDTH +: BIT_WIDTH] = decode_lane(sign_r[g], lane_cnt_s[g]);
    end
  endgenerate

  // Capture results on the first HOLD cycle, once the last sample has landed;
  // keep them stable until consumed and retain them after the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_r  <= {(LANES*BIT_WIDTH){1'b0}};
      sat_r       <= {LANES{1'b0}};
      out_valid_r <= 1'b0;
    end else if ((state_r == ST_HOLD) && !out_valid_r) begin
      out_data_r  <= decoded_s;
      sat_r       <= lane_sat_s;
      out_valid_r <= 1'b1;
    end else if (handshake_s) begin
      out_data_r  <= out_data_r;
      sat_r       <= sat_r;
      out_valid_r <= 1'b0;
    end else begin
      out_data_r  <= out_data_r;
      sat_r       <= sat_r;
      out_valid_r <= out_valid_r;
    end
  end

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign sat       = sat_r;

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Scoreboard bench for unary_stream_decoder (BIT_WIDTH=5, LANES=2, W=16).
module tb_unary_stream_decoder;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sign_in = 2'b00;
  logic [1:0] unary_in = 2'b00;
  logic       busy;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] out_data;
  logic [1:0] sat;

  unary_stream_decoder #(
    .BIT_WIDTH(5),
    .LANES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .sign_in   (sign_in),
    .unary_in  (unary_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0] data;
    logic [1:0] sat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_lane(input logic s, input int n);
    int         c;
    int         v;
    logic [4:0] d;
    c = (n > 15) ? 15 : n;
    v = s ? -c : c;
    d = v[4:0];
    return {(n > 15), d};
  endfunction

  function automatic exp_t model(input logic [1:0] sg, input int n0, input int n1);
    exp_t       e;
    logic [5:0] a;
    logic [5:0] b;
    a = model_lane(sg[0], n0);
    b = model_lane(sg[1], n1);
    e.data = {b[4:0], a[4:0]};
    e.sat  = {b[5], a[5]};
    return e;
  endfunction

  // Output monitor: latency on each rise, data/sat on every valid cycle
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (reset_n) begin
      if (out_valid && !prev_valid && (acc_q.size() > 0)) begin
        a = acc_q.pop_front();
        check_eq("latency", 32'(cyc - a), 32'(W));
      end
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (out_ready) begin
            check_eq("out_data", 32'(out_data), 32'(e.data));
            check_eq("sat", 32'(sat), 32'(e.sat));
            e = exp_q.pop_front();
          end else begin
            check_eq("hold_data", 32'(out_data), 32'(e.data));
            check_eq("hold_sat", 32'(sat), 32'(e.sat));
          end
        end else begin
          check_eq("unexpected_valid", 32'(out_valid), 32'd0);
        end
      end
    end
    prev_valid = out_valid;
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && (t < 100)) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_data"}, 32'(out_data), 32'd0);
    check_eq({tag, "_sat"}, 32'(sat), 32'd0);
  endtask

  // One 16-sample window; optional start pulses in COUNT (with flipped
  // sign), optional reset at sample 8, optional back-to-back start on handshake
  task automatic drive_window(input logic [1:0] sg, input int n0, input int n1,
                              input bit pulse_mid, input bit abort, input bit b2b);
    if (!b2b) wait_idle();
    for (int k = 0; k < W; k++) begin
      start    = (k == 0) || (pulse_mid && ((k == 3) || (k == 7)));
      sign_in  = (k == 0) ? sg : ~sg;
      unary_in = {(k < n1), (k < n0)};
      if ((k == 0) && b2b) out_ready = 1'b1;
      if (abort && (k == 8)) begin
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #3;
        check_reset_outputs("rst_hold");
        start    = 1'b0;
        unary_in = 2'b11;
        reset_n  = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      if ((k == 0) && !abort) begin
        exp_q.push_back(model(sg, n0, n1));
        acc_q.push_back(cyc);
      end
    end
    start    = 1'b0;
    unary_in = 2'b11;
  endtask

  initial begin
    int t;
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    // Single window: +5 on lane0, -11 on lane1
    drive_window(2'b10, 5, 11, 1'b0, 1'b0, 1'b0);
    // Saturation, positive and negative
    drive_window(2'b00, 16, 0, 1'b0, 1'b0, 1'b0);
    drive_window(2'b01, 16, 3, 1'b0, 1'b0, 1'b0);
    // Negative zero with ignored start pulses during COUNT
    drive_window(2'b11, 0, 0, 1'b1, 1'b0, 1'b0);
    drive_window(2'b00, 6, 13, 1'b1, 1'b0, 1'b0);

    // Backpressure for 7 cycles, then handshake and start together
    wait_idle();
    out_ready = 1'b0;
    drive_window(2'b00, 7, 9, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (!out_valid && (t < 40)) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    drive_window(2'b10, 12, 1, 1'b0, 1'b0, 1'b1);

    // Reset mid-window after a saturating window leaves nonzero outputs
    drive_window(2'b00, 16, 16, 1'b0, 1'b0, 1'b0);
    drive_window(2'b00, 16, 16, 1'b0, 1'b1, 1'b0);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    drive_window(2'b01, 9, 14, 1'b0, 1'b0, 1'b0);

    // A few random windows
    for (int r = 0; r < 4; r++) begin
      drive_window(2'($urandom_range(0, 3)), int'($urandom_range(0, 16)),
                   int'($urandom_range(0, 16)), 1'b0, 1'b0, 1'b0);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    check_eq("acc_drain", 32'(acc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
